// File: rtl/a5_lfsr_core.sv
// A5/1 register bank: loads R1/R2/R3 from key and frame, warms up under external
// majority clocking, then packs the keystream into bytes on a valid/ready stream.
module a5_lfsr_core #(
    parameter int NUM_BYTES  = 64,
    parameter int MIX_CYCLES = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] key,
    input  logic [21:0] frame,
    output logic [2:0]  clk_bits,
    input  logic [0:2]  triggers,
    output logic [7:0]  ks_byte,
    output logic        ks_valid,
    input  logic        ks_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_FRAME,
        MIX,
        GEN,
        DRAIN
    } state_e;

    localparam logic [15:0] MIX_LAST  = 16'(MIX_CYCLES - 1);
    localparam logic [15:0] BYTE_LAST = 16'(NUM_BYTES - 1);

    state_e      state_q, state_d;
    logic [18:0] r1_q, r1_d;
    logic [21:0] r2_q, r2_d;
    logic [22:0] r3_q, r3_d;
    logic [63:0] key_q, key_d;
    logic [21:0] frame_q, frame_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [6:0]  asm_q, asm_d;
    logic [7:0]  ks_byte_q, ks_byte_d;
    logic        ks_valid_q, ks_valid_d;
    logic        done_q, done_d;

    logic        z;
    logic        gen_step;

    function automatic logic [18:0] step_r1(input logic [18:0] r, input logic in_bit);
        return {r[17:0], r[13] ^ r[16] ^ r[17] ^ r[18] ^ in_bit};
    endfunction

    function automatic logic [21:0] step_r2(input logic [21:0] r, input logic in_bit);
        return {r[20:0], r[20] ^ r[21] ^ in_bit};
    endfunction

    function automatic logic [22:0] step_r3(input logic [22:0] r, input logic in_bit);
        return {r[21:0], r[7] ^ r[20] ^ r[21] ^ r[22] ^ in_bit};
    endfunction

    // Clock bits come straight off the registers so Maj_logic sees the current state.
    assign clk_bits = {r1_q[8], r2_q[10], r3_q[10]};
    assign z        = r1_q[18] ^ r2_q[21] ^ r3_q[22];
    assign gen_step = !ks_valid_q || ks_ready;

    assign ks_byte  = ks_byte_q;
    assign ks_valid = ks_valid_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

    always_comb begin
        state_d    = state_q;
        r1_d       = r1_q;
        r2_d       = r2_q;
        r3_d       = r3_q;
        key_d      = key_q;
        frame_d    = frame_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        ks_byte_d  = ks_byte_q;
        ks_valid_d = ks_valid_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d      = key;
                    frame_d    = frame;
                    r1_d       = '0;
                    r2_d       = '0;
                    r3_d       = '0;
                    cnt_d      = '0;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    asm_d      = '0;
                    state_d    = LOAD_KEY;
                end
            end
            LOAD_KEY: begin
                r1_d  = step_r1(r1_q, key_q[cnt_q[5:0]]);
                r2_d  = step_r2(r2_q, key_q[cnt_q[5:0]]);
                r3_d  = step_r3(r3_q, key_q[cnt_q[5:0]]);
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == 16'd63) begin
                    cnt_d   = '0;
                    state_d = LOAD_FRAME;
                end
            end
            LOAD_FRAME: begin
                r1_d  = step_r1(r1_q, frame_q[cnt_q[4:0]]);
                r2_d  = step_r2(r2_q, frame_q[cnt_q[4:0]]);
                r3_d  = step_r3(r3_q, frame_q[cnt_q[4:0]]);
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == 16'd21) begin
                    cnt_d   = '0;
                    state_d = MIX;
                end
            end
            MIX: begin
                if (triggers[0]) r1_d = step_r1(r1_q, 1'b0);
                if (triggers[1]) r2_d = step_r2(r2_q, 1'b0);
                if (triggers[2]) r3_d = step_r3(r3_q, 1'b0);
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == MIX_LAST) begin
                    cnt_d   = '0;
                    state_d = GEN;
                end
            end
            GEN: begin
                if (ks_valid_q && ks_ready) ks_valid_d = 1'b0;
                // A completed byte and an acceptance on the same edge overwrite without a bubble.
                if (gen_step) begin
                    if (triggers[0]) r1_d = step_r1(r1_q, 1'b0);
                    if (triggers[1]) r2_d = step_r2(r2_q, 1'b0);
                    if (triggers[2]) r3_d = step_r3(r3_q, 1'b0);
                    asm_d     = {asm_q[5:0], z};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        ks_byte_d  = {asm_q, z};
                        ks_valid_d = 1'b1;
                        byte_cnt_d = byte_cnt_q + 16'd1;
                        if (byte_cnt_q == BYTE_LAST) state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (ks_ready) begin
                    ks_valid_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            r1_q       <= '0;
            r2_q       <= '0;
            r3_q       <= '0;
            key_q      <= '0;
            frame_q    <= '0;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            ks_byte_q  <= '0;
            ks_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            r1_q       <= r1_d;
            r2_q       <= r2_d;
            r3_q       <= r3_d;
            key_q      <= key_d;
            frame_q    <= frame_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            ks_byte_q  <= ks_byte_d;
            ks_valid_q <= ks_valid_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: doc/a5_lfsr_core.md
Name: a5_lfsr_core

Overview:
- A5/1 register bank feeding `Maj_logic`: three LFSRs (R1 19b, R2 22b, R3 23b) loaded from a 64-bit session key and 22-bit frame number.
- Exports the three clocking bits to `Maj_logic` and consumes its `triggers` to clock irregularly.
- Packs the keystream into bytes on a valid/ready stream for the pixel XOR stage of the image-encryption datapath.

Parameters:
- NUM_BYTES, 64, keystream bytes produced per start (1..65535).
- MIX_CYCLES, 100, majority-clocked warm-up cycles with output discarded.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- key  in  64  session key; key[0] loaded first; sampled on the accepted start edge.
- frame  in  22  frame number; frame[0] loaded first; sampled on the accepted start edge.
- clk_bits  out  3  {R1[8], R2[10], R3[10]} driven to `Maj_logic` X, Y, Z.
- triggers  in  [0:2]  from `Maj_logic`; triggers[i]=1 steps register i+1.
- ks_byte  out  8  keystream byte, first-generated bit in bit 7.
- ks_valid  out  1  ks_byte holds an unconsumed byte.
- ks_ready  in  1  downstream accepts when ks_valid && ks_ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last byte is accepted.

Behaviour:
- Reset (asynchronous):
  - R1, R2, R3, assembly shift register, bit and byte counters, ks_byte all 0.
  - ks_valid, busy, done all 0; state IDLE.
  - Asserting rst mid-run aborts immediately; any partial byte is lost.
- Step of a register: shift toward MSB; new bit0 = feedback XOR input bit (input 0 outside the load states).
  - R1 feedback: R1[13]^R1[16]^R1[17]^R1[18].
  - R2 feedback: R2[20]^R2[21].
  - R3 feedback: R3[7]^R3[20]^R3[21]^R3[22].
- Output bit z = R1[18]^R2[21]^R3[22], taken before the step.
- State machine:
  - IDLE: start=1 latches key and frame, zeroes R1–R3, goes to LOAD_KEY.
  - LOAD_KEY: 64 cycles. All three registers step every cycle; input bit key[n] on cycle n; triggers ignored.
  - LOAD_FRAME: 22 cycles, same rule with frame[n].
  - MIX: MIX_CYCLES cycles. Register i steps iff triggers[i-1]; z discarded.
  - GEN: a gen-step occurs on any cycle where (!ks_valid || ks_ready).
    - On a gen-step, registers step per triggers and z shifts into the assembly register LSB.
    - When the 8th bit shifts in, the assembled byte loads ks_byte and ks_valid=1 on the next edge.
    - Acceptance and the next byte's 8th step may coincide: ks_byte is replaced and ks_valid stays 1, giving no bubble.
    - When ks_valid=1 and ks_ready=0, the registers and assembly state hold and ks_byte stays stable.
  - DRAIN: entered after the NUM_BYTES-th byte is loaded into ks_byte. No further steps. On its acceptance: ks_valid=0, done=1 for one cycle, then IDLE.
- start outside IDLE is ignored. key and frame changes after the start edge have no effect.
- triggers is combinational from clk_bits. The block must not register clk_bits in a way that delays it relative to register state.
- Latency: start accepted at edge 0 → ks_valid first rises at edge 64+22+MIX_CYCLES+8 = 194 (defaults), with ks_ready held high.
- Throughput: 1 byte per 8 cycles under continuous ready.
- Byte counter is 16b; NUM_BYTES=1 produces exactly one byte then done.

Test Plan:
1. key=0, frame=0, ks_ready=1 → registers stay 0, every ks_byte=0x00. First ks_valid at edge 194; exactly 64 bytes; done pulses once, one cycle after the 64th acceptance; busy falls with done.
2. key=0x0123456789ABCDEF, frame=0x134 → 64 bytes match the team's bit-accurate C model of A5/1 (same bit ordering); byte-by-byte compare, with `Maj_logic` instantiated.
3. Backpressure: ks_ready=0 for 20 cycles while ks_valid=1 → ks_byte, R1–R3 and clk_bits unchanged. After release the byte sequence equals the one from scenario 2.
4. start pulsed at cycles 10 and 150 of a run with different key → second pulse ignored; output equals the single-start run.
5. rst asserted asynchronously mid-MIX → all outputs 0 immediately (before the next clk edge), state IDLE. A new start then reproduces scenario 2 exactly.
6. Bench forces triggers=3'b000 during GEN → no register steps, so all z bits are identical. triggers=3'b111 → all three registers step every gen-step.
